// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage: counts in-flight writers
// per architectural register and stalls ID while any enabled source is still pending.
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int IDX_W = $clog2(NREGS),
    parameter int NSRC  = 2,
    parameter int NKILL = 2,
    parameter int CNT_W = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_id_valid,
    input  logic [NSRC*IDX_W-1:0]  i_id_rs,
    input  logic [NSRC-1:0]        i_id_en_rs,
    input  logic [IDX_W-1:0]       i_id_rd,
    input  logic                   i_id_en_rd,
    input  logic                   i_id_fire,
    input  logic                   i_wb_valid,
    input  logic [IDX_W-1:0]       i_wb_rd,
    input  logic                   i_wb_en_rd,
    input  logic [NKILL-1:0]       i_kill_valid,
    input  logic [NKILL*IDX_W-1:0] i_kill_rd,
    input  logic [NKILL-1:0]       i_kill_en_rd,
    output logic                   o_data_hazard_ID,
    output logic [NSRC-1:0]        o_hazard_src,
    output logic [NREGS-1:0]       o_busy_vec,
    output logic [31:0]            o_stall_cycles,
    output logic                   o_sb_error
);

    // Wide enough for cnt + 1 - (1 + NKILL) without wrapping; the MSB marks a negative result.
    localparam int SUM_W = CNT_W + $clog2(NKILL + 2) + 1;
    localparam logic [SUM_W-1:0] ONE     = SUM_W'(1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] r_cnt      [1:NREGS-1];
    logic [31:0]      r_stallCycles;
    logic             r_sbError;

    logic [CNT_W-1:0] w_cnt      [NREGS];
    logic [CNT_W-1:0] w_cntNext  [1:NREGS-1];
    logic [NREGS-1:0] w_fault;
    logic [NSRC-1:0]  w_hazardSrc;
    logic [IDX_W-1:0] w_src;
    logic [SUM_W-1:0] w_sum;
    logic             w_hazard;
    logic             w_issue;
    logic             w_err;

    // Register 0 reads as a permanently idle counter.
    always_comb begin
        w_cnt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_cnt[r] = r_cnt[r];
        end
    end

    always_comb begin
        w_hazardSrc = '0;
        w_src       = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_src = i_id_rs[i*IDX_W +: IDX_W];
            if (i_id_valid && i_id_en_rs[i] && (32'(w_src) < NREGS)) begin
                w_hazardSrc[i] = (w_cnt[w_src] != '0);
            end
        end
    end

    assign w_hazard = |w_hazardSrc;
    assign w_issue  = i_id_fire & i_id_valid & i_id_en_rd;

    // Issue, writeback and every kill slot net out in one sum before saturation.
    always_comb begin
        w_fault = '0;
        w_sum   = '0;
        for (int r = 1; r < NREGS; r++) begin
            w_sum = SUM_W'(r_cnt[r]);
            if (w_issue && (i_id_rd == IDX_W'(r))) begin
                w_sum = w_sum + ONE;
            end
            if (i_wb_valid && i_wb_en_rd && (i_wb_rd == IDX_W'(r))) begin
                w_sum = w_sum - ONE;
            end
            for (int k = 0; k < NKILL; k++) begin
                if (i_kill_valid[k] && i_kill_en_rd[k] &&
                    (i_kill_rd[k*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    w_sum = w_sum - ONE;
                end
            end
            if (w_sum[SUM_W-1]) begin
                w_cntNext[r] = '0;
                w_fault[r]   = 1'b1;
            end else if (w_sum > CNT_MAX) begin
                w_cntNext[r] = CNT_MAX[CNT_W-1:0];
                w_fault[r]   = 1'b1;
            end else begin
                w_cntNext[r] = w_sum[CNT_W-1:0];
            end
        end
    end

    // Firing past a stall is still counted so the scoreboard tracks reality, but it is flagged.
    assign w_err = (|w_fault) | (i_id_fire & w_hazard);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int r = 1; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_stallCycles <= '0;
            r_sbError     <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                r_cnt[r] <= w_cntNext[r];
            end
            if (w_hazard) begin
                r_stallCycles <= r_stallCycles + 32'd1;
            end
            if (w_err) begin
                r_sbError <= 1'b1;
            end
        end
    end

    always_comb begin
        o_busy_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            o_busy_vec[r] = (r_cnt[r] != '0);
        end
    end

    assign o_data_hazard_ID = w_hazard;
    assign o_hazard_src     = w_hazardSrc;
    assign o_stall_cycles   = r_stallCycles;
    assign o_sb_error       = r_sbError;

endmodule
